resp_fanout_bridge: RTL and testbench

Response-side companion of the XBAR bridge request fan-in primitive. Records the initiator ID of every granted request in an in-order tracker, then routes each target response back to the owning initiator through a one-cycle registered output stage. Sits between a bridge target port and the N initiator response channels of the L2 TCDM hybrid interconnect.

---
 rtl/resp_bridge_pkg.sv | 24 ++
 rtl/resp_id_fifo.sv | 65 ++++++
 rtl/resp_fanout_bridge.sv | 134 +++++++++++++
 tb/tb_resp_fanout_bridge.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/resp_bridge_pkg.sv
// Shared types and helpers for the response fan-out bridge: tracker entry layout,
// count-width derivation and the one-hot-or-zero check used by the assertions.
package resp_bridge_pkg;

    localparam int RESP_N_INIT_DEF    = 2;
    localparam int RESP_AUX_WIDTH_DEF = 32;
    localparam int MAX_ID_W           = 32;

    // Tracker entry at the default configuration; the top builds the same layout from its parameters.
    typedef struct packed {
        logic [RESP_N_INIT_DEF-1:0]    id;
        logic [RESP_AUX_WIDTH_DEF-1:0] aux;
    } resp_entry_t;

    // Count spans 0..DEPTH inclusive, so it needs one bit more than the pointers.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic is_onehot0(input logic [MAX_ID_W-1:0] v);
        return (v & (v - MAX_ID_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// In-order tracker FIFO. Head entry is read combinationally so the caller can
// register it in the same cycle it is popped; callers qualify push/pop themselves.
module resp_id_fifo
    import resp_bridge_pkg::*;
#(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/resp_fanout_bridge.sv
// Routes in-order target responses back to the owning initiator via a registered
// output stage. Define RESP_FANOUT_ERR_EN to compile in sticky overflow/orphan flags.
module resp_fanout_bridge
    import resp_bridge_pkg::*;
#(
    parameter  int N_INIT     = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int AUX_WIDTH  = 32,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_fire_i,
    input  logic [N_INIT-1:0]     req_ID_i,
    input  logic [AUX_WIDTH-1:0]  req_aux_i,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    output logic [N_INIT-1:0]     r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic [N_INIT-1:0]     r_ID_o,
    output logic [AUX_WIDTH-1:0]  r_aux_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  err_overflow_o,
    output logic                  err_orphan_o
);

    typedef struct packed {
        logic [N_INIT-1:0]    id;
        logic [AUX_WIDTH-1:0] aux;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                push_entry;
    logic [ENTRY_W-1:0]    head_bits;
    entry_t                head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop_en;
    logic                  push_en;

    logic [N_INIT-1:0]     r_valid_reg;
    logic [N_INIT-1:0]     r_valid_next;
    logic [DATA_WIDTH-1:0] r_rdata_reg;
    logic [N_INIT-1:0]     r_id_reg;
    logic [AUX_WIDTH-1:0]  r_aux_reg;

    // A pop at full frees the head slot in the same cycle, so the push may reuse it.
    assign pop_en  = r_valid_i && !fifo_empty;
    assign push_en = req_fire_i && (!fifo_full || pop_en);

    assign push_entry.id  = req_ID_i;
    assign push_entry.aux = req_aux_i;
    assign head_entry     = entry_t'(head_bits);

    resp_id_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .pop   (pop_en),
        .wdata (ENTRY_W'(push_entry)),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_INIT; gi++) begin : g_valid
            assign r_valid_next[gi] = pop_en && head_entry.id[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_reg <= '0;
            r_rdata_reg <= '0;
            r_id_reg    <= '0;
            r_aux_reg   <= '0;
        end else begin
            r_valid_reg <= r_valid_next;
            if (pop_en) begin
                r_rdata_reg <= r_rdata_i;
                r_id_reg    <= head_entry.id;
                r_aux_reg   <= head_entry.aux;
            end
        end
    end

`ifdef RESP_FANOUT_ERR_EN
    logic err_overflow_reg;
    logic err_orphan_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow_reg <= 1'b0;
            err_orphan_reg   <= 1'b0;
        end else begin
            if (req_fire_i && fifo_full && !pop_en) begin
                err_overflow_reg <= 1'b1;
            end
            if (r_valid_i && fifo_empty) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

    assign err_overflow_o = err_overflow_reg;
    assign err_orphan_o   = err_orphan_reg;
`else
    assign err_overflow_o = 1'b0;
    assign err_orphan_o   = 1'b0;
`endif

    assign r_valid_o     = r_valid_reg;
    assign r_rdata_o     = r_rdata_reg;
    assign r_ID_o        = r_id_reg;
    assign r_aux_o       = r_aux_reg;
    assign stall_o       = fifo_full;
    assign outstanding_o = fifo_count;

`ifndef SYNTHESIS
    a_valid_onehot0 : assert property (@(posedge clk) disable iff (rst)
        is_onehot0(MAX_ID_W'(r_valid_o)));
`endif

endmodule

// File: tb/tb_resp_fanout_bridge.sv
// Scoreboard bench for resp_fanout_bridge: directed stimulus queues expected
// responses, a negedge monitor pops and compares whenever r_valid_o is non-zero.
module tb_resp_fanout_bridge;

    logic        clk;
    logic        rst;
    logic        req_fire_i;
    logic [1:0]  req_ID_i;
    logic [31:0] req_aux_i;
    logic        r_valid_i;
    logic [31:0] r_rdata_i;
    logic [1:0]  r_valid_o;
    logic [31:0] r_rdata_o;
    logic [1:0]  r_ID_o;
    logic [31:0] r_aux_o;
    logic        stall_o;
    logic [2:0]  outstanding_o;
    logic        err_overflow_o;
    logic        err_orphan_o;

`ifdef RESP_FANOUT_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic [31:0] aux;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    resp_fanout_bridge #(
        .N_INIT     (2),
        .DATA_WIDTH (32),
        .AUX_WIDTH  (32),
        .DEPTH      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_fire_i     (req_fire_i),
        .req_ID_i       (req_ID_i),
        .req_aux_i      (req_aux_i),
        .r_valid_i      (r_valid_i),
        .r_rdata_i      (r_rdata_i),
        .r_valid_o      (r_valid_o),
        .r_rdata_o      (r_rdata_o),
        .r_ID_o         (r_ID_o),
        .r_aux_o        (r_aux_o),
        .stall_o        (stall_o),
        .outstanding_o  (outstanding_o),
        .err_overflow_o (err_overflow_o),
        .err_orphan_o   (err_orphan_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic fire, input logic [1:0] id, input logic [31:0] aux,
                        input logic rv, input logic [31:0] rd);
        req_fire_i = fire;
        req_ID_i   = id;
        req_aux_i  = aux;
        r_valid_i  = rv;
        r_rdata_i  = rd;
        @(posedge clk);
        #1;
        req_fire_i = 1'b0;
        r_valid_i  = 1'b0;
    endtask

    task automatic expect_resp(input logic [1:0] id, input logic [31:0] data, input logic [31:0] aux);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.aux  = aux;
        sb_q.push_back(e);
    endtask

    // Monitor: one line per routed response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (r_valid_o !== 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: got valid=%b data=0x%0h, required no response",
                             r_valid_o, r_rdata_o);
                end else begin
                    e = sb_q.pop_front();
                    $display("resp: valid=%b id=%b data=0x%0h aux=0x%0h", r_valid_o, r_ID_o, r_rdata_o, r_aux_o);
                    chk("resp_valid", 64'(r_valid_o), 64'(e.id));
                    chk("resp_id",    64'(r_ID_o),    64'(e.id));
                    chk("resp_rdata", 64'(r_rdata_o), 64'(e.data));
                    chk("resp_aux",   64'(r_aux_o),   64'(e.aux));
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"},       64'(r_valid_o),      64'd0);
        chk({tag, "_rdata"},       64'(r_rdata_o),      64'd0);
        chk({tag, "_id"},          64'(r_ID_o),         64'd0);
        chk({tag, "_aux"},         64'(r_aux_o),        64'd0);
        chk({tag, "_stall"},       64'(stall_o),        64'd0);
        chk({tag, "_outstanding"}, 64'(outstanding_o),  64'd0);
        chk({tag, "_err_ovf"},     64'(err_overflow_o), 64'd0);
        chk({tag, "_err_orphan"},  64'(err_orphan_o),   64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_fire_i = 1'b0; req_ID_i = '0; req_aux_i = '0;
        r_valid_i = 1'b0;  r_rdata_i = '0;

        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        chk_reset_state("reset");
        rst = 1'b0;

        // Single read
        step(1, 2'b10, 32'h5, 0, 0);
        chk("single_outstanding1", 64'(outstanding_o), 64'd1);
        expect_resp(2'b10, 32'hDEADBEEF, 32'h5);
        step(0, 2'b00, 0, 1, 32'hDEADBEEF);
        chk("single_outstanding0", 64'(outstanding_o), 64'd0);
        step(0, 2'b00, 0, 0, 0);

        // In-order routing
        step(1, 2'b01, 32'h1, 0, 0);
        step(1, 2'b10, 32'h2, 0, 0);
        step(1, 2'b10, 32'h3, 0, 0);
        step(1, 2'b01, 32'h4, 0, 0);
        expect_resp(2'b01, 32'hA, 32'h1);
        step(0, 2'b00, 0, 1, 32'hA);
        expect_resp(2'b10, 32'hB, 32'h2);
        step(0, 2'b00, 0, 1, 32'hB);
        expect_resp(2'b10, 32'hC, 32'h3);
        step(0, 2'b00, 0, 1, 32'hC);
        expect_resp(2'b01, 32'hD, 32'h4);
        step(0, 2'b00, 0, 1, 32'hD);
        chk("inorder_outstanding0", 64'(outstanding_o), 64'd0);
        step(0, 2'b00, 0, 0, 0);

        // Full, overflow, push+pop at full
        step(1, 2'b01, 32'h10, 0, 0);
        step(1, 2'b10, 32'h11, 0, 0);
        step(1, 2'b01, 32'h12, 0, 0);
        step(1, 2'b10, 32'h13, 0, 0);
        chk("full_stall",       64'(stall_o),       64'd1);
        chk("full_outstanding", 64'(outstanding_o), 64'd4);
        step(1, 2'b01, 32'h99, 0, 0);
        chk("ovf_outstanding", 64'(outstanding_o),  64'd4);
        chk("ovf_flag",        64'(err_overflow_o), 64'(ERR_ON));
        expect_resp(2'b01, 32'h100, 32'h10);
        step(1, 2'b10, 32'h20, 1, 32'h100);
        chk("pushpop_full_outstanding", 64'(outstanding_o), 64'd4);
        chk("pushpop_full_stall",       64'(stall_o),       64'd1);
        expect_resp(2'b10, 32'h101, 32'h11);
        step(0, 2'b00, 0, 1, 32'h101);
        expect_resp(2'b01, 32'h102, 32'h12);
        step(0, 2'b00, 0, 1, 32'h102);
        expect_resp(2'b10, 32'h103, 32'h13);
        step(0, 2'b00, 0, 1, 32'h103);
        expect_resp(2'b10, 32'h104, 32'h20);
        step(0, 2'b00, 0, 1, 32'h104);
        chk("drain_outstanding0", 64'(outstanding_o), 64'd0);
        chk("drain_stall0",       64'(stall_o),       64'd0);
        step(0, 2'b00, 0, 0, 0);

        // Orphan, then orphan with a simultaneous push
        step(0, 2'b00, 0, 1, 32'hBAD);
        chk("orphan_valid", 64'(r_valid_o),    64'd0);
        chk("orphan_flag",  64'(err_orphan_o), 64'(ERR_ON));
        step(1, 2'b01, 32'h7, 1, 32'hBAD2);
        chk("orphan_push_valid",       64'(r_valid_o),     64'd0);
        chk("orphan_push_outstanding", 64'(outstanding_o), 64'd1);
        expect_resp(2'b01, 32'h55, 32'h7);
        step(0, 2'b00, 0, 1, 32'h55);
        step(0, 2'b00, 0, 0, 0);

        // Reset mid-operation
        step(1, 2'b01, 32'h31, 0, 0);
        step(1, 2'b10, 32'h32, 0, 0);
        step(1, 2'b01, 32'h33, 0, 0);
        chk("midrst_outstanding3", 64'(outstanding_o), 64'd3);
        rst = 1'b1;
        step(0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        chk_reset_state("midrst");
        step(0, 2'b00, 0, 1, 32'hCAFE);
        chk("midrst_orphan_valid", 64'(r_valid_o),    64'd0);
        chk("midrst_orphan_flag",  64'(err_orphan_o), 64'(ERR_ON));

        // Wrap-around: overlapped push/pop pairs, pointers wrap twice
        rst = 1'b1;
        step(0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            logic [1:0] id_now;
            logic [1:0] id_prev;
            id_now  = (i % 2 == 1) ? 2'b10 : 2'b01;
            id_prev = (i % 2 == 1) ? 2'b01 : 2'b10;
            if (i > 0) begin
                expect_resp(id_prev, 32'h300 + 32'(i - 1), 32'h200 + 32'(i - 1));
            end
            step(i < 10, id_now, 32'h200 + 32'(i), i > 0, 32'h300 + 32'(i - 1));
        end
        chk("wrap_outstanding0", 64'(outstanding_o),  64'd0);
        chk("wrap_err_ovf",      64'(err_overflow_o), 64'd0);
        chk("wrap_err_orphan",   64'(err_orphan_o),   64'd0);

        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
